subtractor_seq_chunked: RTL and testbench

//  Parametrised multi-cycle ripple-borrow subtractor: computes a - b - bin over WIDTH bits,

---
 rtl/sub_pkg.sv | 25 ++
 rtl/sub_chunk.sv | 22 ++
 rtl/subtractor_seq_chunked.sv | 162 ++++++++++++++++
 tb/tb_subtractor_seq_chunked.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the chunked sequential subtractor: FSM state
// encoding and the index-width helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count n chunks; never less than one so a single-chunk
  // build still has a legal (if unused) index register.
  function automatic int clog2(input int n);
    int r;
    int p;
    r = 32'sd0;
    p = 32'sd1;
    while (p < n) begin
      p = p * 32'sd2;
      r = r + 32'sd1;
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// One CHUNK-bit slice of a ripple-borrow subtractor. Purely combinational;
// the sequential top reuses a single instance every cycle.
module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] res_s;

  // Subtract in CHUNK+1 bits so the top bit falls out as the borrow.
  always_comb begin
    res_s = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
    d     = res_s[CHUNK-1:0];
    bout  = res_s[CHUNK];
  end

endmodule

// File: rtl/subtractor_seq_chunked.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, CHUNK bits per
// clock, with the borrow carried between cycles in a register. Valid/ready
// handshakes on both the operand and the result side.
// Optional feature macro: SUB_SAT_EN (unsigned saturation to zero on borrow).
module subtractor_seq_chunked
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = clog2(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 32'sd1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(32'sd1);

  // Reject operand widths that do not split into whole chunks.
  if ((WIDTH % CHUNK) != 0) begin : g_width_check
    $error("subtractor_seq_chunked: WIDTH must be a multiple of CHUNK");
  end

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [IDXW-1:0]         idx_r;
  logic [WIDTH-1:0]        a_r;
  logic [WIDTH-1:0]        b_r;
  logic                    borrow_r;
  logic [WIDTH-1:0]        diff_r;
  logic                    borrow_out_r;
  logic                    zero_r;

  logic                    accept_s;
  logic                    last_s;
  logic [CHUNK-1:0]        d_s;
  logic                    borrow_nxt_s;
  logic [WIDTH+CHUNK-1:0]  diff_cat_s;
  logic [WIDTH+CHUNK-1:0]  diff_shift_s;
  logic [WIDTH-1:0]        diff_nxt_s;

  // The operand registers are shifted right each BUSY cycle, so the chunk
  // being worked on always sits in the low CHUNK bits.
  sub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_r[CHUNK-1:0]),
    .b    (b_r[CHUNK-1:0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (borrow_nxt_s)
  );

  assign last_s   = (idx_r == LAST_IDX);
  assign in_ready = (state_r == IDLE) | ((state_r == DONE) & out_ready);
  assign accept_s = in_valid & in_ready;

  // New chunk enters at the top of the result and everything moves down one
  // chunk; after NCHUNK steps chunk 0 has reached the bottom.
  always_comb begin
    diff_cat_s   = {d_s, diff_r};
    diff_shift_s = diff_cat_s >> CHUNK;
    diff_nxt_s   = diff_shift_s[WIDTH-1:0];
`ifdef SUB_SAT_EN
    if (last_s && borrow_nxt_s) begin
      diff_nxt_s = {WIDTH{1'b0}};
    end else begin
      diff_nxt_s = diff_shift_s[WIDTH-1:0];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: accept in IDLE, step through chunks in BUSY, hold the
  // result in DONE until it is taken (optionally accepting a new op at once).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_nxt_s = BUSY;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture, per-chunk datapath step and result flags at DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= {IDXW{1'b0}};
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      borrow_r     <= 1'b0;
      diff_r       <= {WIDTH{1'b0}};
      borrow_out_r <= 1'b0;
      zero_r       <= 1'b0;
    end else if (accept_s) begin
      idx_r    <= {IDXW{1'b0}};
      a_r      <= a;
      b_r      <= b;
      borrow_r <= bin;
    end else if (state_r == BUSY) begin
      idx_r    <= idx_r + IDX_ONE;
      a_r      <= a_r >> CHUNK;
      b_r      <= b_r >> CHUNK;
      borrow_r <= borrow_nxt_s;
      diff_r   <= diff_nxt_s;
      if (last_s) begin
        borrow_out_r <= borrow_nxt_s;
        zero_r       <= (diff_nxt_s == {WIDTH{1'b0}});
      end
    end
  end

  assign out_valid  = (state_r == DONE);
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;
  assign zero       = zero_r;

endmodule

// File: tb/tb_subtractor_seq_chunked.sv
// Bench for subtractor_seq_chunked: a whole-width arithmetic model with a
// per-cycle compare process, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_subtractor_seq_chunked;

  localparam int W   = 32;
  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, bin, out_valid, out_ready, borrow_out, zero;
  logic [W-1:0] a, b, diff;
  logic         in_valid1, in_ready1, bin1, out_valid1, out_ready1, borrow_out1, zero1;
  logic [W-1:0] a1, b1, diff1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  subtractor_seq_chunked #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .zero(zero)
  );

  subtractor_seq_chunked #(.WIDTH(W), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .borrow_out(borrow_out1), .zero(zero1)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    int           acc;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    exp_t e;
    full  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    e.d   = full[W-1:0];
    e.bo  = full[W];
`ifdef SUB_SAT_EN
    if (e.bo) e.d = '0;
`endif
    e.z   = (e.d == '0);
    e.acc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model-driven compare: a result is due NCH edges after its acceptance edge
  // and stays until taken; in_ready follows from the model's occupancy.
  always @(negedge clk) begin
    logic exp_ov, exp_ir;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      exp_ov = (q.size() != 0) && (cyc >= q[0].acc + NCH);
      exp_ir = exp_ov ? out_ready : (q.size() == 0);
      check("m_out_valid", 32'(out_valid), 32'(exp_ov));
      check("m_in_ready", 32'(in_ready), 32'(exp_ir));
      if (exp_ov) begin
        check("m_diff", diff, q[0].d);
        check("m_borrow_out", 32'(borrow_out), 32'(q[0].bo));
        check("m_zero", 32'(zero), 32'(q[0].z));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        e = model(a, b, bin);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n;
    a = x; b = y; bin = c; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) check("send_timeout", 32'(n), 32'd0);
    step();
    in_valid = 1'b0; a = $urandom; b = $urandom; bin = 1'b0;
  endtask

  // Negedges from just after the acceptance edge until out_valid is seen;
  // NCH chunk cycles plus the first negedge give NCH+1.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W-1:0] ed, input logic eb, input logic ez);
    int n;
    send(x, y, c);
    wait_out(n);
    check({name, "_lat"}, 32'(n), 32'(NCH + 1));
    check({name, "_diff"}, diff, ed);
    check({name, "_bo"}, 32'(borrow_out), 32'(eb));
    check({name, "_zero"}, 32'(zero), 32'(ez));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] sat_all_ones;
    logic         sat_z;
`ifdef SUB_SAT_EN
    sat_all_ones = 32'h0000_0000; sat_z = 1'b1;
`else
    sat_all_ones = 32'hFFFF_FFFF; sat_z = 1'b0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_diff", diff, 32'h0);
    check("rst_bo", 32'(borrow_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst1_out_valid", 32'(out_valid1), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    directed("t1", 32'h1234_5678, 32'h1, 1'b0, 32'h1234_5677, 1'b0, 1'b0);
    directed("t2", 32'h0000_0100, 32'h1, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
    directed("t3", 32'h0, 32'h1, 1'b0, sat_all_ones, 1'b1, sat_z);
    directed("t4a", 32'h5, 32'h5, 1'b1, sat_all_ones, 1'b1, sat_z);
    directed("t4b", 32'h5, 32'h5, 1'b0, 32'h0, 1'b0, 1'b1);

    // Result held while the consumer stalls, then taken together with a new op.
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0);
    wait_out(n);
    check("t5_lat", 32'(n), 32'(NCH + 1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold_diff", diff, 32'hDEAD_0000);
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_in_ready", 32'(in_ready), 32'd0);
    end
    step();
    out_ready = 1'b1; in_valid = 1'b1; a = 32'd100; b = 32'd58; bin = 1'b1;
    @(negedge clk);
    check("t5_in_ready_comb", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    wait_out(n);
    check("t5_next_lat", 32'(n), 32'(NCH + 1));
    check("t5_next_diff", diff, 32'h0000_0029);
    step();

    // Back-to-back operands; the model checks every result and throughput.
    for (int i = 0; i < 6; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    wait_out(n);
    step();

    // Reset in the middle of BUSY (working on chunk 2) drops the operation.
    send(32'hFFFF_0000, 32'h1, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_result", 32'(out_valid), 32'd0);
    end
    step();
    directed("t6_after", 32'h7, 32'h3, 1'b0, 32'h4, 1'b0, 1'b0);

    // Single-chunk build: result one edge after acceptance.
    a1 = 32'h10; b1 = 32'h3; bin1 = 1'b1; in_valid1 = 1'b1;
    @(negedge clk);
    check("c32_in_ready", 32'(in_ready1), 32'd1);
    step();
    in_valid1 = 1'b0;
    @(negedge clk);
    check("c32_busy", 32'(out_valid1), 32'd0);
    @(negedge clk);
    check("c32_valid", 32'(out_valid1), 32'd1);
    check("c32_diff", diff1, 32'h0000_000C);
    check("c32_bo", 32'(borrow_out1), 32'd0);
    step();
    a1 = 32'h0; b1 = 32'hFFFF_FFFF; bin1 = 1'b1; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("c32b_valid", 32'(out_valid1), 32'd1);
    check("c32b_diff", diff1, 32'h0);
    check("c32b_bo", 32'(borrow_out1), 32'd1);
    check("c32b_zero", 32'(zero1), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
